// File: rtl/key_cmd_gen.sv
// Push-button command source for the motor PWM driver: synchronises and debounces
// five buttons, arbitrates direction ownership and toggles the fast-speed bit.
module key_cmd_gen #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_center,
   output logic [7:0] key_state,
   output logic       cmd_change
);

   localparam int NB = 5;
   localparam int CEN = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      UP,
      DOWN,
      LEFT,
      RIGHT
   } dir_e;

   logic [NB-1:0]            raw;
   logic [NB-1:0]            sync1_q;
   logic [NB-1:0]            sync2_q;
   logic [NB-1:0]            deb_q;
   logic [NB-1:0]            deb_d;
   logic [NB-1:0][CNT_W-1:0] cnt_q;
   logic [NB-1:0][CNT_W-1:0] cnt_d;
   dir_e                     state_q;
   dir_e                     state_d;
   logic                     fast_q;
   logic                     fast_d;
   logic                     cen_prev_q;
   logic [3:0]               dir_nib;
   logic [7:0]               key_q;
   logic [7:0]               key_d;
   logic                     chg_q;

   assign raw = {btn_center, btn_right, btn_left, btn_down, btn_up};

   // A sample equal to the debounced level cancels any pending count.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NB; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   // The owning direction keeps control until it releases; IDLE then re-arbitrates.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (deb_q[0])      state_d = UP;
            else if (deb_q[1]) state_d = DOWN;
            else if (deb_q[2]) state_d = LEFT;
            else if (deb_q[3]) state_d = RIGHT;
         end
         UP:      if (!deb_q[0]) state_d = IDLE;
         DOWN:    if (!deb_q[1]) state_d = IDLE;
         LEFT:    if (!deb_q[2]) state_d = IDLE;
         RIGHT:   if (!deb_q[3]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dir_nib = 4'b0000;
      case (state_q)
         UP:      dir_nib = 4'b0001;
         DOWN:    dir_nib = 4'b0010;
         LEFT:    dir_nib = 4'b0100;
         RIGHT:   dir_nib = 4'b1000;
         default: dir_nib = 4'b0000;
      endcase
      fast_d = fast_q ^ (deb_q[CEN] & ~cen_prev_q);
      key_d  = {1'b0, fast_q, 2'b00, dir_nib};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         cnt_q      <= '0;
         state_q    <= IDLE;
         fast_q     <= 1'b0;
         cen_prev_q <= 1'b0;
         key_q      <= 8'h00;
         chg_q      <= 1'b0;
      end else begin
         sync1_q    <= raw;
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         fast_q     <= fast_d;
         cen_prev_q <= deb_q[CEN];
         key_q      <= key_d;
         chg_q      <= (key_d != key_q);
      end
   end

   assign key_state  = key_q;
   assign cmd_change = chg_q;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Bench for key_cmd_gen: directed scenarios plus random button activity, checked
// every cycle against a window-based behavioural model of debounce and ownership.
module tb_key_cmd_gen;

   localparam int D = 4;
   localparam int CW = 8;

   logic       clk;
   logic       rst;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       btn_center;
   logic [7:0] key_state;
   logic       cmd_change;

   int nAsserts = 0;
   int nFail    = 0;

   // Model: raw history (index 0 newest), debounced levels, owner index (-1 = none).
   logic [4:0] rh [0:D+1];
   logic [4:0] mDeb;
   int         mOwner;
   logic       mRose;
   logic       mFast;
   logic [7:0] mKey;
   logic       mCmd;

   key_cmd_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_center (btn_center),
      .key_state  (key_state),
      .cmd_change (cmd_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic modelReset();
      for (int j = 0; j <= D + 1; j++) rh[j] = 5'b0;
      mDeb   = 5'b0;
      mOwner = -1;
      mRose  = 1'b0;
      mFast  = 1'b0;
      mKey   = 8'h00;
      mCmd   = 1'b0;
   endtask

   // A button's debounced level flips when its last D synchronised samples all disagree with it.
   task automatic modelStep(input logic [4:0] r);
      logic [7:0] newKey;
      logic [3:0] nib;
      logic       flip;
      for (int j = D + 1; j > 0; j--) rh[j] = rh[j-1];
      rh[0] = r;
      nib = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
      newKey = {1'b0, mFast, 2'b00, nib};
      mCmd = (newKey != mKey);
      mKey = newKey;
      if (mOwner < 0) begin
         for (int i = 3; i >= 0; i--) if (mDeb[i]) mOwner = i;
      end else if (!mDeb[mOwner]) begin
         mOwner = -1;
      end
      if (mRose) mFast = ~mFast;
      mRose = 1'b0;
      for (int i = 0; i < 5; i++) begin
         flip = 1'b1;
         for (int j = 2; j <= D + 1; j++) if (rh[j][i] == mDeb[i]) flip = 1'b0;
         if (flip) begin
            if (i == 4 && !mDeb[i]) mRose = 1'b1;
            mDeb[i] = ~mDeb[i];
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      if (rst) modelStep({btn_center, btn_right, btn_left, btn_down, btn_up});
      else modelReset();
      #1;
      checkOutput("key_state", key_state, mKey);
      checkOutput("cmd_change", {7'b0, cmd_change}, {7'b0, mCmd});
   endtask

   task automatic applyStimulus(input logic [4:0] v, input int cycles);
      {btn_center, btn_right, btn_left, btn_down, btn_up} = v;
      for (int i = 0; i < cycles; i++) stepCycle();
   endtask

   // Counts edges after the capturing edge until key_state first shows the target.
   task automatic measureLat(input logic [7:0] target, input int expLat, input string tag);
      int lat;
      lat = -1;
      for (int i = 0; i < 30 && lat < 0; i++) begin
         stepCycle();
         if (key_state === target) lat = i;
      end
      nAsserts++;
      assert (lat === expLat) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, lat, expLat);
      end
   endtask

   initial begin
      logic [4:0] v;
      rst = 1'b0;
      {btn_center, btn_right, btn_left, btn_down, btn_up} = 5'b0;
      modelReset();
      applyStimulus(5'b00000, 3);
      checkOutput("reset_key", key_state, 8'h00);
      rst = 1'b1;
      applyStimulus(5'b00000, 9);

      // Single press and release of up.
      {btn_center, btn_right, btn_left, btn_down, btn_up} = 5'b00001;
      measureLat(8'h01, 7, "up_press_lat");
      applyStimulus(5'b00001, 5);
      {btn_center, btn_right, btn_left, btn_down, btn_up} = 5'b00000;
      measureLat(8'h00, 7, "up_release_lat");
      applyStimulus(5'b00000, 8);

      // Left bouncing every 2 cycles, then steady.
      v = 5'b00000;
      for (int k = 0; k < 20; k++) begin
         v[2] = ~v[2];
         applyStimulus(v, 2);
      end
      checkOutput("bounce_quiet", key_state, 8'h00);
      {btn_center, btn_right, btn_left, btn_down, btn_up} = 5'b00100;
      measureLat(8'h04, 7, "left_settle_lat");
      applyStimulus(5'b00000, 12);

      // Centre toggles fast while down is held.
      applyStimulus(5'b00010, 12);
      checkOutput("down_held", key_state, 8'h02);
      applyStimulus(5'b10010, 10);
      checkOutput("fast_on", key_state, 8'h42);
      applyStimulus(5'b00010, 10);
      applyStimulus(5'b10010, 10);
      applyStimulus(5'b00010, 10);
      checkOutput("fast_off", key_state, 8'h02);
      applyStimulus(5'b00000, 12);

      // Up and right together, then hand over to right.
      applyStimulus(5'b01001, 10);
      checkOutput("up_beats_right", key_state, 8'h01);
      {btn_center, btn_right, btn_left, btn_down, btn_up} = 5'b01000;
      measureLat(8'h00, 7, "handover_gap");
      stepCycle();
      checkOutput("right_takes_over", key_state, 8'h08);
      applyStimulus(5'b00000, 12);

      // Down owns while left is pressed later.
      applyStimulus(5'b00010, 10);
      applyStimulus(5'b00110, 10);
      checkOutput("down_keeps", key_state, 8'h02);
      {btn_center, btn_right, btn_left, btn_down, btn_up} = 5'b00100;
      measureLat(8'h00, 7, "down_release_gap");
      stepCycle();
      checkOutput("left_takes_over", key_state, 8'h04);
      applyStimulus(5'b00000, 12);

      // Asynchronous reset while fast and up are active.
      applyStimulus(5'b10000, 10);
      applyStimulus(5'b00000, 10);
      applyStimulus(5'b00001, 10);
      checkOutput("pre_reset", key_state, 8'h41);
      #2;
      rst = 1'b0;
      #1;
      modelReset();
      checkOutput("async_reset_key", key_state, 8'h00);
      checkOutput("async_reset_cmd", {7'b0, cmd_change}, 8'h00);
      applyStimulus(5'b00001, 2);
      rst = 1'b1;
      measureLat(8'h01, 7, "reset_rearm_lat");
      applyStimulus(5'b00000, 12);

      // Random activity with occasional short bounces.
      for (int k = 0; k < 60; k++) begin
         v = 5'($urandom_range(0, 31));
         applyStimulus(v, $urandom_range(1, 12));
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus(v ^ 5'($urandom_range(1, 31)), 1);
         end
      end
      applyStimulus(5'b00000, 15);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
